// File: rtl/counter_irq_responder.sv
// Host-side responder for the counter controller start/irq/ack handshake.
// Issues start, acknowledges irq_start/irq_done with a four-phase level ack,
// captures the final count and reports per-run results. A per-state watchdog
// moves the block to ERR if the partner stops responding.
module counter_irq_responder #(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 1000,
  parameter int unsigned RUNS_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go,
  input  logic              clear_err,
  input  logic              irq_start,
  input  logic              irq_done,
  input  logic [CNT_W-1:0]  count_in,
  output logic              start,
  output logic              ack,
  output logic              busy,
  output logic [CNT_W-1:0]  result,
  output logic              result_valid,
  output logic              timeout_err,
  output logic [RUNS_W-1:0] runs_done
);

  localparam int unsigned TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_ACK_S  = 3'd2,
    S_WAIT_D = 3'd3,
    S_ACK_D  = 3'd4,
    S_RPT    = 3'd5,
    S_ERR    = 3'd6
  } state_e;

  state_e            state_q, state_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [CNT_W-1:0]  result_q, result_d;
  logic [RUNS_W-1:0] runs_q, runs_d;
  logic              start_q, start_d;
  logic              ack_q, ack_d;
  logic              busy_q, busy_d;
  logic              rv_q, rv_d;
  logic              terr_q, terr_d;
  logic              tmo_limit;
  logic              waiting;

  // Next state, watchdog, capture and Moore outputs decoded from next state
  always_comb begin
    state_d   = state_q;
    tmo_d     = tmo_q;
    result_d  = result_q;
    runs_d    = runs_q;
    tmo_limit = (tmo_q == TMO_W'(TIMEOUT - 1));
    waiting   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (go) state_d = S_REQ;
      end
      S_REQ: begin
        waiting = 1'b1;
        if (irq_start)      state_d = S_ACK_S;
        else if (tmo_limit) state_d = S_ERR;
      end
      S_ACK_S: begin
        waiting = 1'b1;
        if (!irq_start)     state_d = S_WAIT_D;
        else if (tmo_limit) state_d = S_ERR;
      end
      S_WAIT_D: begin
        waiting = 1'b1;
        if (irq_done) begin
          state_d  = S_ACK_D;
          result_d = count_in;
        end else if (tmo_limit) begin
          state_d = S_ERR;
        end
      end
      S_ACK_D: begin
        waiting = 1'b1;
        if (!irq_done) begin
          state_d = S_RPT;
          runs_d  = runs_q + RUNS_W'(1);
        end else if (tmo_limit) begin
          state_d = S_ERR;
        end
      end
      S_RPT: begin
        state_d = S_IDLE;
      end
      S_ERR: begin
        if (clear_err) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Watchdog restarts on every state change, counts only while waiting
    if (state_d != state_q) tmo_d = '0;
    else if (waiting)       tmo_d = tmo_q + TMO_W'(1);

    start_d = (state_d == S_REQ);
    ack_d   = (state_d == S_ACK_S) || (state_d == S_ACK_D);
    busy_d  = (state_d != S_IDLE) && (state_d != S_ERR);
    rv_d    = (state_d == S_RPT);
    terr_d  = (state_d == S_ERR);
  end

  // State, datapath and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      tmo_q    <= '0;
      result_q <= '0;
      runs_q   <= '0;
      start_q  <= 1'b0;
      ack_q    <= 1'b0;
      busy_q   <= 1'b0;
      rv_q     <= 1'b0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmo_q    <= tmo_d;
      result_q <= result_d;
      runs_q   <= runs_d;
      start_q  <= start_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
      rv_q     <= rv_d;
      terr_q   <= terr_d;
    end
  end

  assign start        = start_q;
  assign ack          = ack_q;
  assign busy         = busy_q;
  assign result       = result_q;
  assign result_valid = rv_q;
  assign timeout_err  = terr_q;
  assign runs_done    = runs_q;

endmodule

// File: tb/tb_counter_irq_responder.sv
// Bench for counter_irq_responder: a counter-controller model drives the
// handshake, expected counts go into a scoreboard queue when irq_done is
// raised and are compared when result_valid pulses.
module tb_counter_irq_responder;

  localparam int unsigned CNT_W   = 32;
  localparam int unsigned TIMEOUT = 50;
  localparam int unsigned RUNS_W  = 2;
  localparam int unsigned WAIT_LIM = 200;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              go, clear_err, irq_start, irq_done;
  logic [CNT_W-1:0]  count_in;
  logic              start, ack, busy, result_valid, timeout_err;
  logic [CNT_W-1:0]  result;
  logic [RUNS_W-1:0] runs_done;

  int                n_checks = 0;
  int                n_errors = 0;
  int                pulses   = 0;
  logic [CNT_W-1:0]  sb[$];
  logic [CNT_W-1:0]  last_result = '0;
  logic [RUNS_W-1:0] exp_runs = '0;

  counter_irq_responder #(
    .CNT_W  (CNT_W),
    .TIMEOUT(TIMEOUT),
    .RUNS_W (RUNS_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .go          (go),
    .clear_err   (clear_err),
    .irq_start   (irq_start),
    .irq_done    (irq_done),
    .count_in    (count_in),
    .start       (start),
    .ack         (ack),
    .busy        (busy),
    .result      (result),
    .result_valid(result_valid),
    .timeout_err (timeout_err),
    .runs_done   (runs_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard side: every result_valid pulse consumes one expected count
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (start && ack) check("start_ack_overlap", 32'd1, 32'd0);
      if (result_valid) begin
        pulses++;
        exp_runs = exp_runs + RUNS_W'(1);
        if (sb.size() == 0) begin
          check("sb_unexpected_result", 32'd1, 32'd0);
        end else begin
          last_result = sb.pop_front();
          check("sb_result", result, last_result);
        end
        check("sb_runs_done", 32'(runs_done), 32'(exp_runs));
      end
    end
  end

  // Wait (bounded) for start (which=0) or ack (which=1) to reach lvl
  task automatic wait_out(input int which, input logic lvl, input string tag);
    int n = 0;
    while (((which == 0) ? start : ack) !== lvl && n < WAIT_LIM) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'((which == 0) ? start : ack), 32'(lvl));
  endtask

  // Counter-controller model: answer start, then drop irq_start, then raise
  // irq_done after delay cycles with the given count
  task automatic do_run(input logic [CNT_W-1:0] cnt, input int delay, input bit keep_go);
    wait_out(0, 1'b1, "start_rise");
    if (!keep_go) go = 1'b0;
    check("ack_low_in_req", 32'(ack), 32'd0);
    irq_start = 1'b1;
    wait_out(1, 1'b1, "ack_s_rise");
    check("start_low_in_ack_s", 32'(start), 32'd0);
    irq_start = 1'b0;
    repeat (delay) @(negedge clk);
    count_in = cnt;
    irq_done = 1'b1;
    sb.push_back(cnt);
    @(negedge clk);
    wait_out(1, 1'b1, "ack_d_rise");
    irq_done = 1'b0;
  endtask

  // Bring the FSM into WAIT_D with no irq_done pending
  task automatic to_wait_d();
    go = 1'b1;
    wait_out(0, 1'b1, "start_rise_w");
    go = 1'b0;
    irq_start = 1'b1;
    wait_out(1, 1'b1, "ack_s_rise_w");
    irq_start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "bench timeout");
  end

  initial begin
    int p0;
    rst_n = 1'b0; go = 1'b0; clear_err = 1'b0;
    irq_start = 1'b0; irq_done = 1'b0; count_in = '0;
    repeat (3) @(negedge clk);
    check("rst_flags", 32'({start, ack, busy, result_valid, timeout_err}), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_runs", 32'(runs_done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset mid-run while in WAIT_D: no result, everything back to zero
    to_wait_d();
    repeat (5) @(negedge clk);
    check("wait_d_busy", 32'(busy), 32'd1);
    p0 = pulses;
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_flags", 32'({start, ack, busy, result_valid, timeout_err}), 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_runs", 32'(runs_done), 32'd0);
    rst_n = 1'b1;
    exp_runs = '0;
    last_result = '0;
    repeat (5) @(negedge clk);
    check("midrst_no_pulse", 32'(pulses), 32'(p0));

    // Back-to-back runs with go held high
    p0 = pulses;
    go = 1'b1;
    do_run(32'd5, 3, 1'b1);
    do_run(32'd7, 4, 1'b1);
    do_run(32'd9, 2, 1'b0);
    repeat (4) @(negedge clk);
    check("b2b_pulses", 32'(pulses - p0), 32'd3);
    check("b2b_result", result, 32'd9);
    check("b2b_runs", 32'(runs_done), 32'd3);
    check("b2b_idle", 32'(busy), 32'd0);

    // Nominal run; 4th run overall so the 2-bit run counter wraps to 0
    p0 = pulses;
    go = 1'b1;
    do_run(32'd20, 20, 1'b0);
    repeat (4) @(negedge clk);
    check("nom_pulses", 32'(pulses - p0), 32'd1);
    check("nom_result", result, 32'd20);
    check("nom_runs_wrap", 32'(runs_done), 32'd0);
    check("nom_busy", 32'(busy), 32'd0);

    // Missing irq_done: ERR after TIMEOUT cycles in WAIT_D
    to_wait_d();
    repeat (TIMEOUT) @(negedge clk);
    check("miss_not_yet_err", 32'(timeout_err), 32'd0);
    @(negedge clk);
    check("miss_err", 32'(timeout_err), 32'd1);
    check("miss_ack", 32'(ack), 32'd0);
    check("miss_busy", 32'(busy), 32'd0);
    check("miss_result_hold", result, last_result);
    go = 1'b1;
    repeat (3) @(negedge clk);
    check("err_ignores_go", 32'(timeout_err), 32'd1);
    go = 1'b0;
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    check("clear_err", 32'(timeout_err), 32'd0);
    check("clear_idle", 32'(busy), 32'd0);

    // Stuck irq_start: ack held TIMEOUT cycles, then ERR
    go = 1'b1;
    wait_out(0, 1'b1, "start_rise_stk");
    go = 1'b0;
    irq_start = 1'b1;
    wait_out(1, 1'b1, "ack_rise_stk");
    repeat (TIMEOUT - 1) @(negedge clk);
    check("stuck_ack_held", 32'(ack), 32'd1);
    @(negedge clk);
    check("stuck_ack_drop", 32'(ack), 32'd0);
    check("stuck_err", 32'(timeout_err), 32'd1);
    irq_start = 1'b0;
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;

    // irq_done on the last allowed WAIT_D cycle beats the watchdog
    p0 = pulses;
    go = 1'b1;
    do_run(32'd33, TIMEOUT, 1'b0);
    repeat (4) @(negedge clk);
    check("race_no_err", 32'(timeout_err), 32'd0);
    check("race_pulses", 32'(pulses - p0), 32'd1);
    check("race_result", result, 32'd33);
    check("race_runs", 32'(runs_done), 32'd1);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/counter_irq_responder.md
Name: counter_irq_responder

Overview:
Host-side partner of the AXI counter controller's start/irq/ack handshake.
- Issues `start` and services the `irq_start` and `irq_done` request lines with a level `ack`.
- Captures the final count when the run completes.
- Reports per-run results, with a watchdog that flags a stuck handshake.

Lets the PL run counter measurements autonomously, without a PS interrupt round-trip.

Parameters:
- CNT_W, 32, width of count_in and result.
- TIMEOUT, 1000, max cycles spent in any waiting state before error (must be >=2).
- RUNS_W, 16, width of the runs_done counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- go  in  1  request one measurement run; sampled only in IDLE.
- clear_err  in  1  leave ERR state; sampled only in ERR.
- irq_start  in  1  counter controller's start-acknowledge request.
- irq_done  in  1  counter controller's completion request.
- count_in  in  CNT_W  counter value from the counter datapath.
- start  out  1  run request to the counter controller.
- ack  out  1  acknowledge to the counter controller.
- busy  out  1  high in every state except IDLE and ERR.
- result  out  CNT_W  last captured count.
- result_valid  out  1  one-cycle pulse when result updates.
- timeout_err  out  1  high while in ERR.
- runs_done  out  RUNS_W  completed-run count.

Behaviour:
- Reset: rst_n low at a rising edge puts the block in IDLE. All outputs are 0, the timeout counter is 0, and runs_done is 0. Reset mid-run aborts immediately; no partial result is written.
- All outputs are registered; state is a Moore FSM.
- IDLE:
  - go=1 -> REQ.
  - Outputs: start=0, ack=0.
- REQ:
  - start=1.
  - irq_start=1 -> ACK_S.
  - Timeout -> ERR.
- ACK_S:
  - start=0, ack=1.
  - Stay while irq_start=1; irq_start=0 -> WAIT_D.
  - Timeout -> ERR.
- WAIT_D:
  - ack=0.
  - irq_done=1 -> ACK_D, and capture count_in into result in the same cycle.
  - Timeout -> ERR.
- ACK_D:
  - ack=1.
  - irq_done=0 -> RPT.
  - Timeout -> ERR.
- RPT:
  - One cycle: result_valid=1, runs_done increments (wraps at 2^RUNS_W-1 -> 0).
  - Then -> IDLE.
- ERR:
  - timeout_err=1, start=0, ack=0; result and runs_done hold.
  - clear_err=1 -> IDLE.
- Handshake rule: ack is four-phase. It rises only after the request is seen high, and falls only after the request is seen low. start never overlaps ack.
- Timeout counter:
  - Clears on every state change.
  - Increments each cycle in REQ, ACK_S, WAIT_D and ACK_D.
  - Reaching TIMEOUT-1 with the exit condition still false -> ERR on the next edge.
  - An exit condition true in the same cycle as the limit wins over the timeout.
- go outside IDLE and clear_err outside ERR are ignored; no queuing.
- irq_done seen in REQ or ACK_S is ignored, since only the expected request advances the FSM.
- result holds its value between runs and resets to 0.
- Minimum run, with the counter responding in 1 cycle at each step: go at cycle 0 -> result_valid at cycle ~7. The bench checks ordering, not exact latency.

Test Plan:
1. Nominal run: pulse go. Model raises irq_start 1 cycle after start and drops it 1 cycle after ack. irq_done follows 20 cycles later with count_in=20. Required: result=20, result_valid exactly one pulse, runs_done=1, busy low afterwards.
2. Back-to-back runs: go held high for 3 runs with counts 5, 7 and 9. Required: result sequence 5, 7, 9; runs_done=3; start never high while ack high.
3. Missing irq_done: model never asserts irq_done, TIMEOUT=50. Required: ERR after 50 cycles in WAIT_D, timeout_err=1, ack=0, result unchanged. clear_err -> IDLE, timeout_err=0.
4. Stuck irq_start: model holds irq_start high forever. Required: ack stays 1 for TIMEOUT cycles, then ERR with ack=0.
5. Reset mid-run: rst_n low for 1 cycle while in WAIT_D. Required: all outputs 0 at the next edge, runs_done=0, no result_valid pulse.
6. Wrap and limit race: RUNS_W=2, 4 runs -> runs_done 1, 2, 3, 0. With TIMEOUT=10, irq_done arrives on the 10th WAIT_D cycle -> run completes, no ERR.
